// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one external memory between the CPU and the program loader.
// Each access holds its strobe for WAIT_CYC cycles, then acks the owner for one cycle.
module mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int WAIT_CYC = 2   // legal range 1..15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_own_cpu;
  logic       r_dir;
  logic       r_last_cpu;

  logic w_cpu_req;
  logic w_grant_cpu;

  assign w_cpu_req   = cpu_read | cpu_write;
  // On a tie the side that did not own the previous access wins.
  assign w_grant_cpu = w_cpu_req & (~ld_req | ~r_last_cpu);
  assign cpu_wait    = w_cpu_req & ~cpu_ack;
  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_own_cpu  <= 1'b0;
      r_dir      <= 1'b0;
      r_last_cpu <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
      cpu_ack    <= 1'b0;
      ld_ack     <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ld_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cpu_req | ld_req) begin
            // A CPU request with both read and write high is a write.
            r_own_cpu  <= w_grant_cpu;
            r_last_cpu <= w_grant_cpu;
            r_dir      <= w_grant_cpu ? cpu_write : ld_we;
            mem_addr   <= w_grant_cpu ? cpu_addr : ld_addr;
            mem_wdata  <= w_grant_cpu ? cpu_wdata : ld_wdata;
            mem_rd     <= w_grant_cpu ? ~cpu_write : ~ld_we;
            mem_wr     <= w_grant_cpu ? cpu_write : ld_we;
            r_cnt      <= 4'(WAIT_CYC - 1);
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (!r_dir) begin
              if (r_own_cpu) cpu_rdata <= mem_rdata;
              else           ld_rdata  <= mem_rdata;
            end
            if (r_own_cpu) cpu_ack <= 1'b1;
            else           ld_ack  <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked each cycle against
// a transaction-level model built from grant timestamps and a shadow copy of memory.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_read = 1'b0, cpu_write = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack, cpu_wait;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic [DW-1:0] ld_rdata;
  logic          ld_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rd, mem_wr, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy)
  );

  // Bench-side memory driven by the DUT, and the model's own view of what memory should hold.
  logic [7:0] bmem   [0:65535];
  logic [7:0] shadow [0:65535];
  assign mem_rdata = bmem[mem_addr];

  int checks = 0;
  int errors = 0;

  // Model: one transaction in flight, described by its grant edge g.
  int         e = 0;
  bit         has_txn = 1'b0;
  int         g = 0;
  bit         t_cpu, t_dir;
  logic [15:0] t_addr;
  logic [7:0]  t_wdata;
  int         free_at = 0;
  bit         last_cpu = 1'b0;
  logic [7:0] x_cpu_rdata = '0, x_ld_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    has_txn = 1'b0; last_cpu = 1'b0; free_at = 0;
    x_cpu_rdata = '0; x_ld_rdata = '0;
  endtask

  task automatic model_edge();
    bit creq;
    creq = cpu_read | cpu_write;
    e++;
    if (!rst) begin
      model_reset();
      return;
    end
    if (has_txn && e == g + W) begin
      if (t_dir)      shadow[t_addr] = t_wdata;
      else if (t_cpu) x_cpu_rdata = shadow[t_addr];
      else            x_ld_rdata  = shadow[t_addr];
    end
    if (has_txn && e > g + W) has_txn = 1'b0;
    if (!has_txn && e >= free_at && (creq || ld_req)) begin
      t_cpu    = creq && (!ld_req || !last_cpu);
      last_cpu = t_cpu;
      t_dir    = t_cpu ? cpu_write : ld_we;
      t_addr   = t_cpu ? cpu_addr : ld_addr;
      t_wdata  = t_cpu ? cpu_wdata : ld_wdata;
      has_txn  = 1'b1;
      g        = e;
      free_at  = e + W + 2;
    end
  endtask

  task automatic check_outputs();
    bit str, act, ackc, ackl;
    act  = has_txn && e <= g + W;
    str  = has_txn && e <= g + W - 1;
    ackc = has_txn && e == g + W && t_cpu;
    ackl = has_txn && e == g + W && !t_cpu;
    chk("mem_rd",    32'(mem_rd),    32'(str && !t_dir));
    chk("mem_wr",    32'(mem_wr),    32'(str && t_dir));
    chk("cpu_ack",   32'(cpu_ack),   32'(ackc));
    chk("ld_ack",    32'(ld_ack),    32'(ackl));
    chk("busy",      32'(busy),      32'(act));
    chk("cpu_wait",  32'(cpu_wait),  32'((cpu_read | cpu_write) & !ackc));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(x_cpu_rdata));
    chk("ld_rdata",  32'(ld_rdata),  32'(x_ld_rdata));
    if (str) begin
      chk("mem_addr", 32'(mem_addr), 32'(t_addr));
      if (t_dir) chk("mem_wdata", 32'(mem_wdata), 32'(t_wdata));
    end
    if (!rst) begin
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (mem_wr === 1'b1) bmem[mem_addr] = mem_wdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ack(input string tag, input bit cpu, output int lat, output int nrd, output int nwr);
    bit got;
    got = 1'b0; lat = 0; nrd = 0; nwr = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      step();
      nrd += int'(mem_rd);
      nwr += int'(mem_wr);
      if ((cpu ? cpu_ack : ld_ack) === 1'b1) begin got = 1'b1; lat = i; end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s: ack observed 0 expected 1 within 20 cycles", tag);
    end
  endtask

  task automatic wait_any(input string tag, output bit cpu_won);
    bit got;
    got = 1'b0; cpu_won = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      step();
      if (cpu_ack === 1'b1 || ld_ack === 1'b1) begin got = 1'b1; cpu_won = cpu_ack; end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s: ack observed 0 expected 1 within 20 cycles", tag);
    end
  endtask

  function automatic logic [15:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
  endfunction

  initial begin
    int lat, nrd, nwr;
    bit won;
    bit cpu_act, ld_act;
    logic [7:0] saved;
    for (int i = 0; i < 65536; i++) begin
      bmem[i]   = 8'($urandom);
      shadow[i] = bmem[i];
    end
    bmem[16'h0010] = 8'hA5; shadow[16'h0010] = 8'hA5;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      cpu_read = 1'($urandom); cpu_write = 1'($urandom); ld_req = 1'($urandom); ld_we = 1'($urandom);
      cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); ld_addr = 16'($urandom); ld_wdata = 8'($urandom);
      step();
    end
    cpu_read = 1'b0; cpu_write = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    step();
    rst = 1'b1;
    idle(2);

    // First CPU read after reset.
    cpu_read = 1'b1; cpu_addr = 16'h0010;
    wait_ack("cpu_rd", 1'b1, lat, nrd, nwr);
    chk("cpu_rd_lat", 32'(lat), 32'd3);
    chk("cpu_rd_strobes", 32'(nrd), 32'd2);
    chk("cpu_rd_data", 32'(cpu_rdata), 32'hA5);
    chk("cpu_wait_in_ack", 32'(cpu_wait), 32'd0);
    cpu_read = 1'b0;
    idle(2);

    // Loader write.
    saved = cpu_rdata;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0100; ld_wdata = 8'h3C;
    wait_ack("ld_wr", 1'b0, lat, nrd, nwr);
    chk("ld_wr_lat", 32'(lat), 32'd3);
    chk("ld_wr_strobes", 32'(nwr), 32'd2);
    chk("ld_wr_no_rd", 32'(nrd), 32'd0);
    ld_req = 1'b0;
    step();
    chk("ld_wr_mem", 32'(bmem[16'h0100]), 32'h3C);
    chk("ld_wr_cpu_rdata_kept", 32'(cpu_rdata), 32'(saved));
    idle(2);

    // Four ties; loser withdraws, so the winner alternates starting with the CPU.
    for (int t = 0; t < 4; t++) begin
      cpu_write = 1'b1; cpu_addr = rnd_addr(); cpu_wdata = 8'($urandom);
      ld_req = 1'b1; ld_we = 1'($urandom); ld_addr = rnd_addr(); ld_wdata = 8'($urandom);
      wait_any("tie", won);
      chk($sformatf("tie%0d_winner_cpu", t), 32'(won), 32'((t % 2) == 0));
      cpu_write = 1'b0; ld_req = 1'b0;
      idle(3);
    end
    // Tie with both held: CPU first, loader granted in the next IDLE.
    cpu_write = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h11;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0020;
    wait_any("tie_held", won);
    chk("tie_held_first_cpu", 32'(won), 32'd1);
    cpu_write = 1'b0;
    wait_ack("tie_held_ld", 1'b0, lat, nrd, nwr);
    chk("tie_held_ld_lat", 32'(lat), 32'd4);
    chk("tie_held_ld_data", 32'(ld_rdata), 32'h11);
    ld_req = 1'b0;
    idle(2);

    // Read and write together is a write.
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 8'h77;
    wait_ack("cpu_rw", 1'b1, lat, nrd, nwr);
    chk("cpu_rw_wr", 32'(nwr), 32'd2);
    chk("cpu_rw_rd", 32'(nrd), 32'd0);
    cpu_read = 1'b0; cpu_write = 1'b0;
    idle(3);
    chk("cpu_rw_mem", 32'(bmem[16'h0030]), 32'h77);

    // Reset during the second access cycle of a loader read.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0040;
    step();
    step();
    cpu_read = 1'b1; cpu_addr = 16'h0050;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ld_ack", 32'(ld_ack), 32'd0);
    model_reset();
    idle(2);
    rst = 1'b1;
    wait_any("post_rst", won);
    chk("post_rst_cpu_first", 32'(won), 32'd1);
    cpu_read = 1'b0;
    wait_ack("post_rst_ld", 1'b0, lat, nrd, nwr);
    ld_req = 1'b0;
    idle(2);

    // CPU stalled while the loader owns the bus.
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0060;
    step();
    cpu_read = 1'b1; cpu_addr = 16'h0061;
    wait_ack("stall", 1'b1, lat, nrd, nwr);
    chk("stall_lat", 32'(lat), 32'd6);
    cpu_read = 1'b0; ld_req = 1'b0;
    idle(W + 4);

    // Loader request dropped mid-access still completes.
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0070; ld_wdata = 8'h5A;
    step();
    ld_addr = 16'h0071; ld_wdata = 8'hFF;
    step();
    ld_req = 1'b0;
    wait_ack("drop", 1'b0, lat, nrd, nwr);
    chk("drop_lat", 32'(lat), 32'd1);
    idle(3);
    chk("drop_mem", 32'(bmem[16'h0070]), 32'h5A);

    // Random traffic: requests held until acked, address/data wiggled while waiting.
    cpu_act = 1'b0; ld_act = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (cpu_act && cpu_ack === 1'b1) begin
        cpu_act = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
      end else if (!cpu_act && $urandom_range(0, 2) == 0) begin
        cpu_act = 1'b1;
        case ($urandom_range(0, 3))
          0, 3:    begin cpu_read = 1'b1; cpu_write = 1'b0; end
          1:       begin cpu_read = 1'b0; cpu_write = 1'b1; end
          default: begin cpu_read = 1'b1; cpu_write = 1'b1; end
        endcase
        cpu_addr = rnd_addr(); cpu_wdata = 8'($urandom);
      end else if (cpu_act && $urandom_range(0, 3) == 0) begin
        cpu_addr = rnd_addr(); cpu_wdata = 8'($urandom);
      end
      if (ld_act && ld_ack === 1'b1) begin
        ld_act = 1'b0; ld_req = 1'b0;
      end else if (!ld_act && $urandom_range(0, 2) == 0) begin
        ld_act = 1'b1; ld_req = 1'b1; ld_we = 1'($urandom);
        ld_addr = rnd_addr(); ld_wdata = 8'($urandom);
      end else if (ld_act && $urandom_range(0, 3) == 0) begin
        ld_addr = rnd_addr(); ld_wdata = 8'($urandom);
      end
    end
    cpu_read = 1'b0; cpu_write = 1'b0; ld_req = 1'b0;
    idle(W + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
